// File: rtl/sr_ignition_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sr_ignition_arbiter
//  Purpose  : Round-robin arbiter that hands one of four coherence request
//             channels to a shared ignition controller. It follows the
//             controller's phase through one event and latches the phase
//             durations for the consciousness state at grant time.
//  Revision : 1.0  initial release
// ============================================================================
module sr_ignition_arbiter #(
   parameter int WIDTH       = 18,
   parameter int COH_THRESH  = 12288,
   parameter int ARM_TIMEOUT = 16,
   parameter int FAST_SIM    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clk_en,
   input  logic [4*WIDTH-1:0] req_coh,
   input  logic [3:0]         req_beta_quiet,
   input  logic [2:0]         state_sel,
   input  logic [2:0]         ign_phase,
   output logic [WIDTH-1:0]   coherence_out,
   output logic               beta_quiet_out,
   output logic [3:0]         grant,
   output logic [15:0]        phase2_dur,
   output logic [15:0]        phase3_dur,
   output logic [15:0]        phase4_dur,
   output logic [15:0]        phase5_dur,
   output logic [15:0]        phase6_dur,
   output logic [15:0]        refractory,
   output logic               busy,
   output logic [15:0]        event_count
);

   localparam logic signed [WIDTH-1:0] c_thresh = WIDTH'(COH_THRESH);
   localparam int                      CW       = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
   localparam logic [CW-1:0]           c_arm_last = CW'(ARM_TIMEOUT - 1);
   localparam logic [2:0]              c_ph_base  = 3'd0;
   localparam logic [2:0]              c_ph_refr  = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   // Duration row {p2, p3, p4, p5, p6, refr}; undefined selectors fall back to NORMAL.
   function automatic logic [95:0] f_row(input logic [2:0] sel);
      logic [95:0] r;
      case (sel)
         3'd1:    r = {16'd12000, 16'd12000, 16'd16000, 16'd48000, 16'd20000, 16'd30000};
         3'd2:    r = {16'd8000,  16'd6000,  16'd8000,  16'd24000, 16'd12000, 16'd20000};
         3'd3:    r = {16'd10000, 16'd8000,  16'd12000, 16'd40000, 16'd16000, 16'd32000};
         3'd4:    r = {16'd20000, 16'd14000, 16'd6000,  16'd16000, 16'd24000, 16'd60000};
         default: r = {16'd14000, 16'd10000, 16'd10000, 16'd36000, 16'd16000, 16'd40000};
      endcase
      if (FAST_SIM != 0) begin
         for (int i = 0; i < 6; i++) begin
            r[i*16 +: 16] = r[i*16 +: 16] / 16'd10;
         end
      end
      return r;
   endfunction

   localparam logic [95:0] c_rst_row = f_row(3'd0);

   state_t                  r_state;
   logic [1:0]              r_rr_ptr;
   logic [1:0]              r_win;
   logic [CW-1:0]           r_arm_cnt;

   logic signed [WIDTH-1:0] w_coh_ch [4];
   logic [3:0]              w_elig;
   logic                    w_any;
   logic [1:0]              w_sel;
   logic [WIDTH-1:0]        w_coh_win;
   logic                    w_bq_win;
   logic [95:0]             w_row;

   generate
      for (genvar g = 0; g < 4; g++) begin : g_ch
         assign w_coh_ch[g] = req_coh[g*WIDTH +: WIDTH];
         assign w_elig[g]   = req_beta_quiet[g] && (w_coh_ch[g] >= c_thresh);
      end
   endgenerate

   assign w_coh_win = w_coh_ch[r_win];
   assign w_bq_win  = req_beta_quiet[r_win];
   assign w_row     = f_row(state_sel);

   // Pick the first eligible channel at or above the round-robin pointer (wrapping).
   always_comb begin
      w_any = 1'b0;
      w_sel = r_rr_ptr;
      for (int k = 3; k >= 0; k--) begin
         if (w_elig[r_rr_ptr + 2'(k)]) begin
            w_any = 1'b1;
            w_sel = r_rr_ptr + 2'(k);
         end
      end
   end

   // Arbitration FSM with all outputs registered; advances only on clk_en ticks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_rr_ptr       <= 2'd0;
         r_win          <= 2'd0;
         r_arm_cnt      <= '0;
         grant          <= 4'd0;
         coherence_out  <= '0;
         beta_quiet_out <= 1'b0;
         busy           <= 1'b0;
         event_count    <= 16'd0;
         {phase2_dur, phase3_dur, phase4_dur, phase5_dur, phase6_dur, refractory} <= c_rst_row;
      end else if (clk_en) begin
         case (r_state)
            ST_IDLE: begin
               grant          <= 4'd0;
               coherence_out  <= '0;
               beta_quiet_out <= 1'b0;
               busy           <= 1'b0;
               if (w_any) begin
                  r_state        <= ST_ARM;
                  r_win          <= w_sel;
                  r_arm_cnt      <= '0;
                  grant          <= 4'b0001 << w_sel;
                  busy           <= 1'b1;
                  coherence_out  <= w_coh_ch[w_sel];
                  beta_quiet_out <= req_beta_quiet[w_sel];
                  {phase2_dur, phase3_dur, phase4_dur, phase5_dur, phase6_dur, refractory} <= w_row;
               end
            end
            ST_ARM: begin
               coherence_out  <= w_coh_win;
               beta_quiet_out <= w_bq_win;
               if (ign_phase != c_ph_base) begin
                  r_state <= ST_HOLD;
               end else if (r_arm_cnt == c_arm_last) begin
                  // Controller never started: give up and move the pointer past this winner.
                  r_state        <= ST_IDLE;
                  r_rr_ptr       <= r_win + 2'd1;
                  grant          <= 4'd0;
                  busy           <= 1'b0;
                  coherence_out  <= '0;
                  beta_quiet_out <= 1'b0;
               end else begin
                  r_arm_cnt <= r_arm_cnt + 1'b1;
               end
            end
            ST_HOLD: begin
               coherence_out  <= w_coh_win;
               beta_quiet_out <= w_bq_win;
               if (ign_phase == c_ph_refr) begin
                  r_state        <= ST_DRAIN;
                  coherence_out  <= '0;
                  beta_quiet_out <= 1'b0;
               end else if (ign_phase == c_ph_base) begin
                  // Controller aborted mid-event: release without counting.
                  r_state        <= ST_IDLE;
                  grant          <= 4'd0;
                  busy           <= 1'b0;
                  coherence_out  <= '0;
                  beta_quiet_out <= 1'b0;
               end
            end
            default: begin
               coherence_out  <= '0;
               beta_quiet_out <= 1'b0;
               if (ign_phase == c_ph_base) begin
                  r_state  <= ST_IDLE;
                  r_rr_ptr <= r_win + 2'd1;
                  grant    <= 4'd0;
                  busy     <= 1'b0;
                  if (event_count != 16'hFFFF) begin
                     event_count <= event_count + 16'd1;
                  end
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sr_ignition_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sr_ignition_arbiter
//  Purpose  : Self-checking bench: table of single-grant vectors plus
//             hand-written event sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sr_ignition_arbiter;

   localparam int W = 18;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           clk_en = 1'b0;
   logic [4*W-1:0] req_coh = '0;
   logic [3:0]     req_beta_quiet = 4'd0;
   logic [2:0]     state_sel = 3'd0;
   logic [2:0]     ign_phase = 3'd0;
   logic [W-1:0]   coherence_out;
   logic           beta_quiet_out;
   logic [3:0]     grant;
   logic [15:0]    phase2_dur, phase3_dur, phase4_dur, phase5_dur, phase6_dur, refractory;
   logic           busy;
   logic [15:0]    event_count;

   int n_checks = 0;
   int n_pass   = 0;

   sr_ignition_arbiter #(
      .WIDTH(W), .COH_THRESH(12288), .ARM_TIMEOUT(16), .FAST_SIM(1)
   ) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .req_coh(req_coh), .req_beta_quiet(req_beta_quiet),
      .state_sel(state_sel), .ign_phase(ign_phase),
      .coherence_out(coherence_out), .beta_quiet_out(beta_quiet_out),
      .grant(grant),
      .phase2_dur(phase2_dur), .phase3_dur(phase3_dur), .phase4_dur(phase4_dur),
      .phase5_dur(phase5_dur), .phase6_dur(phase6_dur), .refractory(refractory),
      .busy(busy), .event_count(event_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4*W-1:0] coh;
      logic [3:0]     bq;
      logic [3:0]     exp_grant;
      logic [W-1:0]   exp_coh;
   } vec_t;

   vec_t tbl [8];

   localparam logic [95:0] c_normal = {16'd1400, 16'd1000, 16'd1000, 16'd3600, 16'd1600, 16'd4000};
   localparam logic [95:0] c_psy    = {16'd800,  16'd600,  16'd800,  16'd2400, 16'd1200, 16'd2000};

   function automatic logic [4*W-1:0] mk(input int c3, input int c2, input int c1, input int c0);
      return {W'(c3), W'(c2), W'(c1), W'(c0)};
   endfunction

   function automatic logic [95:0] durs();
      return {phase2_dur, phase3_dur, phase4_dur, phase5_dur, phase6_dur, refractory};
   endfunction

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      clk_en = 1'b1;
      @(posedge clk);
      #1;
      clk_en = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #13;
      rst = 1'b0;
      #1;
   endtask

   task automatic ph(input logic [2:0] p);
      ign_phase = p;
      tick();
   endtask

   initial begin
      tbl[0] = '{mk(0, 0, 0, 0),                   4'b0000, 4'b0000, W'(0)};
      tbl[1] = '{mk(0, 0, 12287, 0),               4'b0010, 4'b0000, W'(0)};
      tbl[2] = '{mk(0, 0, 16384, 0),               4'b0000, 4'b0000, W'(0)};
      tbl[3] = '{mk(0, 0, 12288, 0),               4'b0010, 4'b0010, W'(12288)};
      tbl[4] = '{mk(14000, 0, 0, 12288),           4'b1001, 4'b0001, W'(12288)};
      tbl[5] = '{mk(13000, 0, 0, -20000),          4'b1001, 4'b1000, W'(13000)};
      tbl[6] = '{mk(0, 131071, 12288, 0),          4'b0110, 4'b0010, W'(12288)};
      tbl[7] = '{mk(20000, 20000, 20000, 15000),   4'b1111, 4'b0001, W'(15000)};

      // Reset state
      do_reset();
      chk("rst_grant", 96'(grant), 96'(4'd0));
      chk("rst_busy", 96'(busy), 96'(1'b0));
      chk("rst_coh", 96'(coherence_out), 96'(0));
      chk("rst_bq", 96'(beta_quiet_out), 96'(1'b0));
      chk("rst_count", 96'(event_count), 96'(16'd0));
      chk("rst_durs", durs(), c_normal);

      // Table: single grant decision from rr_ptr=0
      for (int i = 0; i < 8; i++) begin
         do_reset();
         req_coh = tbl[i].coh;
         req_beta_quiet = tbl[i].bq;
         tick();
         chk($sformatf("vec%0d_grant", i), 96'(grant), 96'(tbl[i].exp_grant));
         chk($sformatf("vec%0d_busy", i), 96'(busy), 96'(tbl[i].exp_grant != 4'd0));
         chk($sformatf("vec%0d_coh", i), 96'(coherence_out), 96'(tbl[i].exp_coh));
      end

      // (a) full event on ch2
      do_reset();
      state_sel = 3'd0;
      req_coh = mk(0, 12288, 0, 0);
      req_beta_quiet = 4'b0100;
      tick();
      chk("a_grant", 96'(grant), 96'(4'b0100));
      ph(3'd1);
      chk("a_hold_coh", 96'(coherence_out), 96'(12288));
      chk("a_hold_bq", 96'(beta_quiet_out), 96'(1'b1));
      ph(3'd2); ph(3'd3); ph(3'd4); ph(3'd5); ph(3'd6);
      chk("a_drain_grant", 96'(grant), 96'(4'b0100));
      ph(3'd0);
      chk("a_idle_grant", 96'(grant), 96'(4'd0));
      chk("a_count", 96'(event_count), 96'(16'd1));
      chk("a_rr_ptr", 96'(dut.r_rr_ptr), 96'(2'd3));
      chk("a_durs", durs(), c_normal);
      req_beta_quiet = 4'd0;

      // (b) ch0 and ch3 together: ch0 first, then ch3
      do_reset();
      req_coh = mk(12288, 0, 0, 12288);
      req_beta_quiet = 4'b1001;
      tick();
      chk("b_first", 96'(grant), 96'(4'b0001));
      ph(3'd1); ph(3'd6); ph(3'd0);
      chk("b_count1", 96'(event_count), 96'(16'd1));
      tick();
      chk("b_second", 96'(grant), 96'(4'b1000));
      ph(3'd1); ph(3'd6); ph(3'd0);
      chk("b_count2", 96'(event_count), 96'(16'd2));
      req_beta_quiet = 4'd0;

      // (d) ARM timeout; requests dropped right after grant must not release it
      do_reset();
      ign_phase = 3'd0;
      req_coh = mk(0, 0, 12288, 0);
      req_beta_quiet = 4'b0010;
      tick();
      req_beta_quiet = 4'd0;
      for (int i = 0; i < 15; i++) tick();
      chk("d_still_busy", 96'(busy), 96'(1'b1));
      chk("d_still_grant", 96'(grant), 96'(4'b0010));
      tick();
      chk("d_idle_busy", 96'(busy), 96'(1'b0));
      chk("d_idle_grant", 96'(grant), 96'(4'd0));
      chk("d_count", 96'(event_count), 96'(16'd0));
      chk("d_rr_ptr", 96'(dut.r_rr_ptr), 96'(2'd2));

      // (e) durations latched at grant, state_sel change ignored; DRAIN zeroes outputs
      do_reset();
      state_sel = 3'd2;
      req_coh = mk(0, 0, 0, 16000);
      req_beta_quiet = 4'b0001;
      tick();
      chk("e_durs_grant", durs(), c_psy);
      ph(3'd1);
      state_sel = 3'd0;
      ph(3'd3);
      chk("e_durs_hold", durs(), c_psy);
      ph(3'd6);
      chk("e_drain_coh", 96'(coherence_out), 96'(0));
      chk("e_drain_bq", 96'(beta_quiet_out), 96'(1'b0));
      chk("e_durs_drain", durs(), c_psy);
      req_beta_quiet = 4'd0;
      ph(3'd0);
      chk("e_durs_end", durs(), c_psy);
      chk("e_count", 96'(event_count), 96'(16'd1));

      // (f) asynchronous reset during HOLD after one counted event
      do_reset();
      state_sel = 3'd2;
      req_coh = mk(0, 0, 0, 16000);
      req_beta_quiet = 4'b0001;
      tick(); ph(3'd1); ph(3'd6); ph(3'd0);
      tick(); ph(3'd1);
      chk("f_pre_busy", 96'(busy), 96'(1'b1));
      #2;
      rst = 1'b1;
      #1;
      chk("f_grant", 96'(grant), 96'(4'd0));
      chk("f_busy", 96'(busy), 96'(1'b0));
      chk("f_coh", 96'(coherence_out), 96'(0));
      chk("f_bq", 96'(beta_quiet_out), 96'(1'b0));
      chk("f_count", 96'(event_count), 96'(16'd0));
      chk("f_durs", durs(), c_normal);
      #3;
      rst = 1'b0;
      req_beta_quiet = 4'd0;
      ign_phase = 3'd0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
